// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encodings,
// default program base address and header length.
package imem_loader_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_1000;
  localparam int          HDR_BYTES         = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    LOAD  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } state_t;

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Little-endian 8->32 assembler: the first byte of each group lands in bits [7:0];
// word_valid pulses combinationally in the cycle the fourth byte is accepted.
module imem_loader_byte_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  cnt;
  logic [23:0] sr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (byte_valid) begin
      cnt <= cnt + 2'd1;
    end
  end

  // Only the three earlier bytes need storage; the fourth is taken straight from the input.
  always_ff @(posedge clk) begin
    if (byte_valid) begin
      sr <= {byte_data, sr[23:8]};
    end
  end

  assign word       = {byte_data, sr};
  assign word_valid = byte_valid && (cnt == 2'(HDR_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed little-endian byte stream into instruction memory and
// releases the cpu from reset only after a complete, valid load.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int          DEPTH     = 64,
  parameter int          CNT_W     = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             imem_we,
  output logic [31:0]      imem_addr,
  output logic [31:0]      imem_wdata,
  output logic             cpu_rst_n,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] words_loaded
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] word_idx, n_words;
  logic [31:0]      addr_q, wdata_q;
  logic [31:0]      word;
  logic             word_valid;
  logic             take, launch, hdr_bad, last_word;

  assign in_ready  = (state_q == HDR) || (state_q == LOAD);
  assign busy      = (state_q == HDR) || (state_q == LOAD) || (state_q == WRITE);
  assign done      = (state_q == DONE);
  assign error     = (state_q == ERROR);
  assign cpu_rst_n = (state_q == DONE);
  assign imem_we   = (state_q == WRITE);
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;

  assign take      = in_valid && in_ready;
  assign launch    = start && !busy;
  assign hdr_bad   = (word == 32'd0) || (word > 32'(DEPTH));
  assign last_word = (word_idx == n_words - CNT_W'(1));

  imem_loader_byte_assembler u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (launch),
    .byte_valid (take),
    .byte_data  (in_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        if (start) state_d = HDR;
      HDR:         if (word_valid) state_d = hdr_bad ? ERROR : LOAD;
      LOAD:        if (word_valid) state_d = WRITE;
      WRITE:       state_d = last_word ? DONE : LOAD;
      DONE, ERROR: if (start) state_d = HDR;
      default:     state_d = IDLE;
    endcase
  end

  // Address/data are latched as the word completes so they are stable during WRITE
  // and keep the last written values afterwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_idx     <= '0;
      n_words      <= '0;
      words_loaded <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      if (launch) begin
        word_idx     <= '0;
        words_loaded <= '0;
      end
      if (state_q == HDR && word_valid && !hdr_bad) begin
        n_words  <= word[CNT_W-1:0];
        word_idx <= '0;
      end
      if (state_q == LOAD && word_valid) begin
        addr_q  <= BASE_ADDR + (32'(word_idx) << 2);
        wdata_q <= word;
      end
      if (state_q == WRITE) begin
        words_loaded <= words_loaded + CNT_W'(1);
        if (!last_word) word_idx <= word_idx + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: program loads with and without back-pressure,
// bad headers, full-depth load, mid-load reset and start pulses in busy/done states.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n, start, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, imem_we, cpu_rst_n, busy, done, error;
  logic [31:0] imem_addr, imem_wdata;
  logic [6:0]  words_loaded;

  int errors = 0;
  int checks = 0;
  int we_cnt = 0;
  bit bp = 1'b0;
  logic [63:0] wq[$];
  logic [31:0] prog[4] = '{32'hFFC4A303, 32'h0064A423, 32'h0062E233, 32'hFE420AE3};

  always #5 clk = ~clk;

  imem_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_rst_n    (cpu_rst_n),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always @(negedge clk) begin
    if (imem_we) begin
      wq.push_back({imem_addr, imem_wdata});
      we_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    if (bp) repeat ($urandom_range(0, 3)) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("byte_accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    while (!done && !error && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(done | error), 32'd1);
  endtask

  task automatic clear_log();
    wq.delete();
    we_cnt = 0;
  endtask

  task automatic load_prog(input bit mid_start);
    send_word(32'd4);
    for (int i = 0; i < 4; i++) begin
      send_word(prog[i]);
      if (mid_start && i == 1) pulse_start();
    end
  endtask

  task automatic check_prog(input string tag);
    check({tag, "_nwrites"}, 32'(we_cnt), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check({tag, "_addr"}, wq.size() > i ? wq[i][63:32] : 32'hDEAD_BEEF, 32'h1000 + 32'(4 * i));
      check({tag, "_data"}, wq.size() > i ? wq[i][31:0] : 32'hDEAD_BEEF, prog[i]);
    end
    check({tag, "_done"},  32'(done), 32'd1);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_cpu"},   32'(cpu_rst_n), 32'd1);
    check({tag, "_words"}, 32'(words_loaded), 32'd4);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_outs", {imem_addr[7:0], imem_wdata[7:0], 9'(words_loaded),
                       imem_we, in_ready, cpu_rst_n, busy, done, error, 1'b0}, 32'd0);
    rst_n = 1'b1;

    // 1: basic program load
    clear_log();
    pulse_start();
    check("t1_in_ready", 32'(in_ready), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    load_prog(1'b0);
    wait_end("t1_end");
    check_prog("t1");
    check("t1_addr_hold", imem_addr, 32'h100C);

    // 2: same stream under back-pressure
    bp = 1'b1;
    clear_log();
    pulse_start();
    load_prog(1'b0);
    wait_end("t2_end");
    check_prog("t2");
    bp = 1'b0;

    // 3: zero-length header, then recovery
    clear_log();
    pulse_start();
    send_word(32'd0);
    wait_end("t3_end");
    @(negedge clk);
    check("t3_error", 32'(error), 32'd1);
    check("t3_done", 32'(done), 32'd0);
    check("t3_cpu", 32'(cpu_rst_n), 32'd0);
    check("t3_in_ready", 32'(in_ready), 32'd0);
    check("t3_nwrites", 32'(we_cnt), 32'd0);
    pulse_start();
    load_prog(1'b0);
    wait_end("t3b_end");
    check_prog("t3b");

    // 4: oversize header rejected, then a full-depth load
    clear_log();
    pulse_start();
    send_word(32'd65);
    wait_end("t4_end");
    check("t4_error", 32'(error), 32'd1);
    check("t4_nwrites", 32'(we_cnt), 32'd0);
    pulse_start();
    send_word(32'd64);
    for (int i = 0; i < 64; i++) send_word(32'h5A00_0000 + 32'(i));
    wait_end("t4b_end");
    check("t4b_done", 32'(done), 32'd1);
    check("t4b_nwrites", 32'(we_cnt), 32'd64);
    check("t4b_first_addr", wq.size() > 0 ? wq[0][63:32] : 32'hDEAD_BEEF, 32'h1000);
    check("t4b_last_addr", wq.size() == 64 ? wq[63][63:32] : 32'hDEAD_BEEF, 32'h10FC);
    check("t4b_last_data", wq.size() == 64 ? wq[63][31:0] : 32'hDEAD_BEEF, 32'h5A00_003F);
    check("t4b_words", 32'(words_loaded), 32'd64);

    // 5: reset after two words, then restart from scratch
    clear_log();
    pulse_start();
    send_word(32'd4);
    send_word(prog[0]);
    send_word(prog[1]);
    repeat (2) @(negedge clk);
    check("t5_partial", 32'(we_cnt), 32'd2);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_rst_outs", {imem_addr[7:0], imem_wdata[7:0], 9'(words_loaded),
                          imem_we, in_ready, cpu_rst_n, busy, done, error, 1'b0}, 32'd0);
    rst_n = 1'b1;
    clear_log();
    pulse_start();
    check("t5_words_zero", 32'(words_loaded), 32'd0);
    load_prog(1'b0);
    wait_end("t5_end");
    check_prog("t5");

    // 6: start in DONE restarts; start mid-load is ignored
    clear_log();
    pulse_start();
    check("t6_cpu", 32'(cpu_rst_n), 32'd0);
    check("t6_in_ready", 32'(in_ready), 32'd1);
    check("t6_done", 32'(done), 32'd0);
    check("t6_words", 32'(words_loaded), 32'd0);
    load_prog(1'b1);
    wait_end("t6_end");
    check_prog("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
